// File: rtl/prediction_update_scheduler.sv
// prediction_update_scheduler
//   Single write-port scheduler for the branch prediction table.
//   - hi requests (EX stage) win the port outright.
//   - lo requests (ID stage) wait in a small FIFO.
//   - After reset and on flush_req, every table entry is written with COUNTER_INIT_VALUE.
//   - A hi write to index X invalidates any queued lo entry for X, so an older ID
//     update can never land after a newer EX update.
// Optional feature macro: PUS_STATS_EN adds the stat_dropped / stat_superseded counters.
module prediction_update_scheduler #(
  parameter int INDEX_WIDTH        = 8,
  parameter int COUNTER_WIDTH      = 2,
  parameter int COUNTER_INIT_VALUE = 0,
  parameter int FIFO_AW            = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_req,
  input  logic                     hi_valid,
  input  logic [INDEX_WIDTH-1:0]   hi_index,
  input  logic [COUNTER_WIDTH-1:0] hi_count,
  input  logic                     lo_valid,
  input  logic [INDEX_WIDTH-1:0]   lo_index,
  input  logic [COUNTER_WIDTH-1:0] lo_count,
  output logic                     lo_ready,
`ifdef PUS_STATS_EN
  output logic [15:0]              stat_dropped,
  output logic [15:0]              stat_superseded,
`endif
  output logic                     wr_en,
  output logic [INDEX_WIDTH-1:0]   wr_index,
  output logic [COUNTER_WIDTH-1:0] wr_count,
  output logic                     busy
);

  localparam int                     DEPTH    = 2 ** FIFO_AW;
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = '1;
  localparam logic [COUNTER_WIDTH-1:0] INIT_CNT = COUNTER_WIDTH'(COUNTER_INIT_VALUE);

  typedef enum logic [0:0] {ST_SWEEP = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                   state_r, state_s;
  logic [INDEX_WIDTH-1:0]   sweep_ptr_r, sweep_ptr_s;
  logic [FIFO_AW:0]         rd_ptr_r, wr_ptr_r;
  logic [INDEX_WIDTH-1:0]   fifo_idx_r [DEPTH];
  logic [COUNTER_WIDTH-1:0] fifo_cnt_r [DEPTH];
  logic [DEPTH-1:0]         fifo_vld_r;

  logic                     wr_en_s;
  logic [INDEX_WIDTH-1:0]   wr_index_s;
  logic [COUNTER_WIDTH-1:0] wr_count_s;
  logic                     busy_s;

  logic                     fifo_full_s, fifo_empty_s;
  logic [FIFO_AW-1:0]       head_slot_s, tail_slot_s;
  logic                     run_s, hi_take_s, pop_s, push_s, lo_stale_s;
  logic [DEPTH-1:0]         match_s;

  assign head_slot_s  = rd_ptr_r[FIFO_AW-1:0];
  assign tail_slot_s  = wr_ptr_r[FIFO_AW-1:0];
  assign fifo_empty_s = (rd_ptr_r == wr_ptr_r);
  assign fifo_full_s  = (rd_ptr_r[FIFO_AW] != wr_ptr_r[FIFO_AW]) &&
                        (head_slot_s == tail_slot_s);
  assign lo_ready     = !fifo_full_s && (state_r == ST_RUN);

  // Per-cycle decode of what the RUN datapath does this edge
  always_comb begin
    run_s      = (state_r == ST_RUN) && !flush_req;
    hi_take_s  = run_s && hi_valid;
    pop_s      = run_s && !hi_valid && !fifo_empty_s;
    push_s     = run_s && lo_valid && lo_ready;
    lo_stale_s = hi_take_s && (lo_index == hi_index);
    for (int i = 0; i < DEPTH; i++) begin
      match_s[i] = fifo_vld_r[i] && (fifo_idx_r[i] == hi_index);
    end
  end

  // State and sweep pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_SWEEP;
      sweep_ptr_r <= '0;
    end else begin
      state_r     <= state_s;
      sweep_ptr_r <= sweep_ptr_s;
    end
  end

  // Next-state: sweep until the last index is written, flush always restarts it
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_SWEEP: begin
        if (flush_req)                   state_s = ST_SWEEP;
        else if (sweep_ptr_r == LAST_IDX) state_s = ST_RUN;
        else                             state_s = ST_SWEEP;
      end
      ST_RUN: begin
        if (flush_req) state_s = ST_SWEEP;
        else           state_s = ST_RUN;
      end
      default: state_s = ST_SWEEP;
    endcase
  end

  // Output decode: next values of the registered write port and sweep pointer
  always_comb begin
    wr_en_s     = 1'b0;
    wr_index_s  = wr_index;
    wr_count_s  = wr_count;
    sweep_ptr_s = sweep_ptr_r;
    busy_s      = (state_s == ST_SWEEP);
    if (flush_req) begin
      sweep_ptr_s = '0;
    end else begin
      case (state_r)
        ST_SWEEP: begin
          wr_en_s     = 1'b1;
          wr_index_s  = sweep_ptr_r;
          wr_count_s  = INIT_CNT;
          sweep_ptr_s = sweep_ptr_r + INDEX_WIDTH'(1);
        end
        ST_RUN: begin
          if (hi_valid) begin
            wr_en_s    = 1'b1;
            wr_index_s = hi_index;
            wr_count_s = hi_count;
          end else if (pop_s && fifo_vld_r[head_slot_s]) begin
            wr_en_s    = 1'b1;
            wr_index_s = fifo_idx_r[head_slot_s];
            wr_count_s = fifo_cnt_r[head_slot_s];
          end else begin
            wr_en_s    = 1'b0;
          end
        end
        default: wr_en_s = 1'b0;
      endcase
    end
  end

  // Registered table write port and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en    <= 1'b0;
      wr_index <= '0;
      wr_count <= INIT_CNT;
      busy     <= 1'b1;
    end else begin
      wr_en    <= wr_en_s;
      wr_index <= wr_index_s;
      wr_count <= wr_count_s;
      busy     <= busy_s;
    end
  end

  // lo FIFO: supersede on hi, pop clears the slot valid bit, push writes the tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      fifo_vld_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_idx_r[i] <= '0;
        fifo_cnt_r[i] <= '0;
      end
    end else if (flush_req) begin
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      fifo_vld_r <= '0;
    end else begin
      if (hi_take_s) begin
        fifo_vld_r <= fifo_vld_r & ~match_s;
      end
      if (pop_s) begin
        rd_ptr_r                <= rd_ptr_r + (FIFO_AW+1)'(1);
        fifo_vld_r[head_slot_s] <= 1'b0;
      end
      if (push_s) begin
        wr_ptr_r                <= wr_ptr_r + (FIFO_AW+1)'(1);
        fifo_idx_r[tail_slot_s] <= lo_index;
        fifo_cnt_r[tail_slot_s] <= lo_count;
        fifo_vld_r[tail_slot_s] <= !lo_stale_s;
      end
    end
  end

`ifdef PUS_STATS_EN
  localparam int SW = $clog2(DEPTH + 2);

  logic          drop_s;
  logic [SW-1:0] sup_n_s;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [16:0] inc);
    logic [16:0] sum;
    sum = {1'b0, a} + inc;
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // Count lo drops and entries invalidated by a hi write this cycle
  always_comb begin
    drop_s  = (state_r == ST_RUN) && lo_valid && !lo_ready;
    sup_n_s = '0;
    if (hi_take_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        sup_n_s = sup_n_s + SW'(match_s[i]);
      end
    end else begin
      sup_n_s = '0;
    end
    if (push_s && lo_stale_s) sup_n_s = sup_n_s + SW'(1);
    else                      sup_n_s = sup_n_s;
  end

  // Saturating statistics counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_dropped    <= 16'h0000;
      stat_superseded <= 16'h0000;
    end else begin
      stat_dropped    <= sat_add(stat_dropped, {16'h0000, drop_s});
      stat_superseded <= sat_add(stat_superseded, 17'(sup_n_s));
    end
  end
`endif

endmodule

// File: tb/tb_prediction_update_scheduler.sv
// Scoreboard bench for prediction_update_scheduler (small table, INDEX_WIDTH=3).
module tb_prediction_update_scheduler;

  localparam int IW    = 3;
  localparam int CW    = 2;
  localparam int INIT  = 1;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int N     = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush_req = 1'b0;
  logic          hi_valid = 1'b0;
  logic [IW-1:0] hi_index = '0;
  logic [CW-1:0] hi_count = '0;
  logic          lo_valid = 1'b0;
  logic [IW-1:0] lo_index = '0;
  logic [CW-1:0] lo_count = '0;
  logic          lo_ready;
  logic          wr_en;
  logic [IW-1:0] wr_index;
  logic [CW-1:0] wr_count;
  logic          busy;
`ifdef PUS_STATS_EN
  logic [15:0]   stat_dropped;
  logic [15:0]   stat_superseded;
`endif

  prediction_update_scheduler #(
    .INDEX_WIDTH(IW), .COUNTER_WIDTH(CW), .COUNTER_INIT_VALUE(INIT), .FIFO_AW(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush_req(flush_req),
    .hi_valid(hi_valid), .hi_index(hi_index), .hi_count(hi_count),
    .lo_valid(lo_valid), .lo_index(lo_index), .lo_count(lo_count),
    .lo_ready(lo_ready),
`ifdef PUS_STATS_EN
    .stat_dropped(stat_dropped), .stat_superseded(stat_superseded),
`endif
    .wr_en(wr_en), .wr_index(wr_index), .wr_count(wr_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int cnt; bit vld; } ent_t;
  typedef struct { int idx; int cnt; int cyc; } exp_t;

  ent_t m_fifo[$];
  exp_t exp_q[$];
  bit   m_sweep;
  int   m_ptr;
  int   m_drop;
  int   m_sup;
  int   cyc;
  int   errors;
  int   checks;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push_exp(input int idx, input int cnt);
    exp_t x;
    x.idx = idx; x.cnt = cnt; x.cyc = cyc + 1;
    exp_q.push_back(x);
  endtask

  // Drive one cycle of inputs, advance the reference model, then check status outputs.
  task automatic step(input bit fl, input bit hv, input int hi, input int hc,
                      input bit lv, input int li, input int lc);
    bit   rdy;
    ent_t e;
    flush_req = fl;
    hi_valid  = hv; hi_index = IW'(hi); hi_count = CW'(hc);
    lo_valid  = lv; lo_index = IW'(li); lo_count = CW'(lc);
    rdy = !m_sweep && (m_fifo.size() < DEPTH);
    if (!m_sweep && lv && !rdy) m_drop++;
    if (fl) begin
      m_sweep = 1'b1;
      m_ptr   = 0;
      m_fifo.delete();
    end else if (m_sweep) begin
      push_exp(m_ptr, INIT);
      if (m_ptr == N - 1) m_sweep = 1'b0;
      m_ptr = (m_ptr + 1) % N;
    end else begin
      if (hv) begin
        push_exp(hi, hc);
        foreach (m_fifo[i]) begin
          if (m_fifo[i].vld && m_fifo[i].idx == hi) begin
            m_fifo[i].vld = 1'b0;
            m_sup++;
          end
        end
      end else if (m_fifo.size() > 0) begin
        e = m_fifo.pop_front();
        if (e.vld) push_exp(e.idx, e.cnt);
      end
      if (lv && rdy) begin
        e.idx = li; e.cnt = lc; e.vld = !(hv && li == hi);
        if (!e.vld) m_sup++;
        m_fifo.push_back(e);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    chk("busy", int'(busy), int'(m_sweep));
    chk("lo_ready", int'(lo_ready), int'(!m_sweep && (m_fifo.size() < DEPTH)));
`ifdef PUS_STATS_EN
    chk("stat_dropped", int'(stat_dropped), m_drop);
    chk("stat_superseded", int'(stat_superseded), m_sup);
`endif
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
  endtask

  initial begin
    exp_t x;
    errors = 0; checks = 0; cyc = 0;
    m_sweep = 1'b1; m_ptr = 0; m_drop = 0; m_sup = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wr_en", int'(wr_en), 0);
    chk("reset_wr_index", int'(wr_index), 0);
    chk("reset_wr_count", int'(wr_count), INIT);
    chk("reset_busy", int'(busy), 1);
    chk("reset_lo_ready", int'(lo_ready), 0);

    fork
      forever begin
        @(negedge clk);
        if (wr_en) begin
          chk("write_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("wr_index", int'(wr_index), x.idx);
            chk("wr_count", int'(wr_count), x.cnt);
            chk("wr_cycle", cyc, x.cyc);
          end
        end
      end
    join_none

    rst_n = 1'b1;

    // Sweep after reset: idx 0..7, busy falls with the last write
    idle(N);
    idle(1);
    // Single hi request
    step(1'b0, 1'b1, 5, 3, 1'b0, 0, 0);
    idle(2);
    // Back-to-back lo requests
    step(1'b0, 1'b0, 0, 0, 1'b1, 2, 1);
    step(1'b0, 1'b0, 0, 0, 1'b1, 4, 0);
    idle(3);
    // Fill FIFO while hi is held; the fifth lo is dropped
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 7, k % 4, 1'b1, k, (k + 1) % 4);
    idle(6);
    // Queued lo superseded by a hi to the same index
    step(1'b0, 1'b0, 0, 0, 1'b1, 6, 1);
    step(1'b0, 1'b1, 6, 2, 1'b0, 0, 0);
    idle(3);
    // Flush with three entries queued
    for (int k = 1; k <= 3; k++) step(1'b0, 1'b1, 0, 2, 1'b1, k, k);
    step(1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
    idle(N + 3);
    // Randomized traffic with occasional flushes
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 3) == 0, int'($urandom_range(0, N - 1)), int'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1, int'($urandom_range(0, N - 1)), int'($urandom_range(0, 3)));
    end
    idle(N + 8);
    chk("exp_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
